mem_arbiter: RTL and testbench

//   Shares the single unified memory (A/WD/We/RD, combinational read, write on

---
 rtl/mem_arb_pkg.sv | 17 +
 rtl/mem_arb_rr2.sv | 23 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    // Owner of the current access; also the encoding of the last winner.
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Wait-state counter width; covers WAIT_CYCLES 0..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr2.sv
// Two-way round-robin picker. req[0] is the fetch port, req[1] the data port.
// On a tie the requester that did not win last time is chosen.
module mem_arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       grant
);

    // Winner selection: single requester wins outright, tie goes to !last.
    always_comb begin
        valid = |req;
        grant = OWN_I;
        if (req[1] && req[0]) begin
            grant = ~last;
        end else if (req[1]) begin
            grant = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one combinational-read memory between the instruction-fetch
// port and the data port. One access at a time: IDLE picks a winner and
// latches its request, ACCESS burns WAIT_CYCLES then reads/writes, DONE acks.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int WAIT_CYCLES = 1
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_We,
    input  logic [DATA_W-1:0] mem_RD,
    output logic              busy
);

    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

    arb_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             owner;
    logic             last;
    logic             we_lat;
    logic             pick_vld;
    logic             pick;
    logic             fire;

    mem_arb_rr2 u_rr (
        .req   ({d_req, i_req}),
        .last  (last),
        .valid (pick_vld),
        .grant (pick)
    );

    // The cycle in which the memory is actually read or written.
    assign fire = (state == ACCESS) && (cnt == '0);

    // Write strobe is combinational and gated by rst so a reset edge never commits.
    assign mem_We = fire && we_lat && rst;
    assign busy   = (state != IDLE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ACCESS;
            ACCESS:  if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Request latches, wait counter, read-data capture and ack pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            owner   <= OWN_I;
            last    <= OWN_D;
            we_lat  <= 1'b0;
            mem_A   <= '0;
            mem_WD  <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            i_ack   <= 1'b0;
            d_ack   <= 1'b0;
        end else begin
            // Acks are registered so they are high exactly during DONE.
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner  <= pick;
                        last   <= pick;
                        cnt    <= WAIT_INIT;
                        mem_A  <= (pick == OWN_D) ? d_addr : i_addr;
                        mem_WD <= (pick == OWN_D) ? d_wdata : '0;
                        we_lat <= d_we && (pick == OWN_D);
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!we_lat) begin
                            if (owner == OWN_D) d_rdata <= mem_RD;
                            else                i_rdata <= mem_RD;
                        end
                        i_ack <= (owner == OWN_I);
                        d_ack <= (owner == OWN_D);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level reference model (grant time stamps,
// fixed latency arithmetic, a reference memory array).
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int W = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int tcyc   = 0;
    always @(posedge clk) tcyc <= tcyc + 1;

    // Main DUT (WAIT_CYCLES=1)
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic        i_ack, d_ack, mem_We, busy;
    logic [31:0] i_rdata, d_rdata, mem_A, mem_WD, mem_RD;
    logic [31:0] mem     [0:255];
    logic [31:0] ref_mem [0:255];

    mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_We(mem_We), .mem_RD(mem_RD),
        .busy(busy)
    );

    assign mem_RD = mem[mem_A[9:2]];
    always @(posedge clk) if (mem_We) mem[mem_A[9:2]] <= mem_WD;

    // Latency DUTs: index 0 -> WAIT_CYCLES=0, index 1 -> WAIT_CYCLES=3 (fetch only)
    logic        f_req  [2];
    logic [31:0] f_addr [2];
    logic        f_iack [2], f_dack [2], f_we [2], f_busy [2];
    logic [31:0] f_irdata [2], f_drdata [2], f_a [2], f_wd [2], f_rd [2];
    logic [31:0] fmem [0:15];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        mem_arbiter #(.DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(g == 0 ? 0 : 3)) u_lat (
            .clk(clk), .rst(rst),
            .i_req(f_req[g]), .i_addr(f_addr[g]), .i_ack(f_iack[g]), .i_rdata(f_irdata[g]),
            .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
            .d_ack(f_dack[g]), .d_rdata(f_drdata[g]),
            .mem_A(f_a[g]), .mem_WD(f_wd[g]), .mem_We(f_we[g]), .mem_RD(f_rd[g]),
            .busy(f_busy[g])
        );
        assign f_rd[g] = fmem[f_a[g][5:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    bit          m_act = 1'b0;
    int          m_g = 0;
    bit          m_own = 1'b0, m_we = 1'b0, m_last = 1'b1;
    logic [31:0] m_addr = '0, m_wd = '0, m_a = '0, m_wdo = '0, m_ir = '0, m_dr = '0;

    task automatic model_step();
        int ack_at, we_at;
        bit idle;
        ack_at = m_g + W + 2;
        we_at  = m_g + W + 1;
        chk("m_busy",  busy,    32'(m_act && cyc > m_g && cyc <= ack_at));
        chk("m_i_ack", i_ack,   32'(m_act && cyc == ack_at && !m_own));
        chk("m_d_ack", d_ack,   32'(m_act && cyc == ack_at && m_own));
        chk("m_we",    mem_We,  32'(m_act && m_we && cyc == we_at && rst));
        chk("m_addr",  mem_A,   m_a);
        chk("m_wd",    mem_WD,  m_wdo);
        chk("m_irdat", i_rdata, m_ir);
        chk("m_drdat", d_rdata, m_dr);
        if (!rst) begin
            m_act = 1'b0; m_a = '0; m_wdo = '0; m_ir = '0; m_dr = '0; m_last = 1'b1;
        end else begin
            idle = !m_act;
            if (m_act && cyc == we_at) begin
                if (m_we)       ref_mem[m_addr[9:2]] = m_wd;
                else if (m_own) m_dr = ref_mem[m_addr[9:2]];
                else            m_ir = ref_mem[m_addr[9:2]];
            end
            if (m_act && cyc == ack_at) m_act = 1'b0;
            if (idle && (i_req || d_req)) begin
                m_own  = (i_req && d_req) ? !m_last : d_req;
                m_last = m_own;
                m_g    = cyc;
                m_act  = 1'b1;
                m_addr = m_own ? d_addr : i_addr;
                m_wd   = m_own ? d_wdata : 32'd0;
                m_we   = m_own && d_we;
                m_a    = m_addr;
                m_wdo  = m_wd;
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(negedge clk);
        model_step();
    end

    // One access on the main DUT; lat = cycles from request to ack (-1 on timeout).
    task automatic access(input bit dside, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, output int lat);
        if (dside) begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd; end
        else       begin i_req = 1'b1; i_addr = addr; end
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (dside ? d_ack : i_ack) begin lat = n; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1);
    end

    initial begin
        int          lat, ni, nd, k;
        logic [2:0]  ord;
        logic        ia, da;
        logic [31:0] old, dsave;
        int          t [3];

        for (int a = 0; a < 256; a++) begin
            mem[a]     = 32'hC000_0000 + 32'(a);
            ref_mem[a] = 32'hC000_0000 + 32'(a);
        end
        for (int a = 0; a < 16; a++) fmem[a] = 32'h0;
        fmem[2] = 32'hDEAD_BEEF;
        f_req[0] = 1'b0; f_req[1] = 1'b0;
        f_addr[0] = '0;  f_addr[1] = '0;

        // 1: reset with both requests high
        rst = 1'b0; i_req = 1'b1; d_req = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_iack", i_ack, 0);
        chk("rst_dack", d_ack, 0);
        chk("rst_we",   mem_We, 0);
        chk("rst_addr", mem_A, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0; rst = 1'b1;
        @(posedge clk); #1;

        // 3: contention right after reset: fetch, data, fetch
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        ni = 0; nd = 0; ord = '0;
        for (int n = 0; n < 60 && (i_req || d_req); n++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            chk("cont_excl", 32'(ia & da), 0);
            if (ia) begin ord = {ord[1:0], 1'b0}; ni++; end
            if (da) begin ord = {ord[1:0], 1'b1}; nd++; end
            @(posedge clk); #1;
            if (ia && ni == 2) i_req = 1'b0;
            if (da && nd == 1) d_req = 1'b0;
        end
        chk("cont_order", 32'(ord), 32'b010);
        chk("cont_count", ni + nd, 3);

        // 2: data write then read back
        access(1'b1, 1'b1, 32'd100, 32'h11, lat);
        chk("wr_lat", lat, W + 2);
        chk("wr_mem", mem[25], 32'h11);
        access(1'b1, 1'b0, 32'd100, 32'h0, lat);
        chk("rd_lat", lat, W + 2);
        chk("rd_data", d_rdata, 32'h11);

        // 5: reset in the write cycle of an access
        old = mem[50];
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'd200; d_wdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("abort_we", mem_We, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_ack", d_ack, 0);
        @(posedge clk); #1;
        chk("abort_mem", mem[50], old);

        // 6: back-to-back fetches with i_req held
        dsave = d_rdata; k = 0;
        i_req = 1'b1; i_addr = 32'd0;
        for (int n = 0; n < 60 && k < 3; n++) begin
            @(negedge clk);
            ia = i_ack;
            if (ia) begin
                chk("b2b_data", i_rdata, 32'hC000_0000 + 32'(k));
                t[k] = tcyc;
                k++;
            end
            @(posedge clk); #1;
            if (ia) begin
                if (k == 3) i_req = 1'b0;
                else        i_addr = 32'(4 * k);
            end
        end
        i_req = 1'b0;
        chk("b2b_count", k, 3);
        chk("b2b_gap1", t[1] - t[0], W + 3);
        chk("b2b_gap2", t[2] - t[1], W + 3);
        chk("b2b_drdata", d_rdata, dsave);

        // 4: fetch latency at WAIT_CYCLES=0 and 3
        for (int g = 0; g < 2; g++) begin
            f_req[g] = 1'b1; f_addr[g] = 32'd8;
            lat = -1;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (f_iack[g]) begin lat = n; break; end
                @(posedge clk); #1;
            end
            chk(g == 0 ? "lat_w0" : "lat_w3", lat, g == 0 ? 2 : 5);
            chk(g == 0 ? "dat_w0" : "dat_w3", f_irdata[g], 32'hDEAD_BEEF);
            @(posedge clk); #1;
            f_req[g] = 1'b0;
        end

        // Random traffic on the main DUT, checked by the model
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            @(posedge clk); #1;
            if (!i_req || ia) begin
                i_req  = ($urandom_range(0, 2) != 0);
                i_addr = {22'd0, 8'($urandom), 2'b00};
            end
            if (!d_req || da) begin
                d_req   = ($urandom_range(0, 2) != 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = {22'd0, 8'($urandom), 2'b00};
                d_wdata = $urandom;
            end
        end
        for (int n = 0; n < 100 && (i_req || d_req || busy); n++) begin
            @(negedge clk);
            ia = i_ack; da = d_ack;
            @(posedge clk); #1;
            if (ia) i_req = 1'b0;
            if (da) d_req = 1'b0;
        end
        chk("drain", 32'(i_req | d_req | busy), 0);
        for (int a = 0; a < 256; a++) chk("final_mem", mem[a], ref_mem[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
